// File: rtl/dac_playback_tx_if.sv
// dac_playback_tx_if: AXI4-Stream sample-beat bundle toward one DAC tile.
// master drives data/valid/last, slave returns ready.
interface dac_playback_tx_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/dac_playback_tx.sv
// dac_playback_tx: block-RAM waveform player feeding the RFDC DAC stream.
// Optional SYSREF-aligned start; output path takes arbitrary backpressure.
module dac_playback_tx #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_BITS  = 9,
  parameter int LOOP_BITS  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_BITS-1:0]  length,
  input  logic [LOOP_BITS-1:0]  loops,
  input  logic                  sysref_align,
  input  logic                  sysref,
  input  logic                  start,
  input  logic                  stop,
  dac_playback_tx_if.master     m_axis,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE, ARM, RUN, DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_BITS-1:0] len_q, len_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LOOP_BITS-1:0] loops_q, loops_d;
  logic [LOOP_BITS-1:0] pass_q, pass_d;
  logic sysref_q, rise;
  logic fetch_ok_q, fetch, last_rd;
  logic done_d;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] ram_q;
  logic ram_vld_q, ram_last_q;

  logic [DATA_WIDTH-1:0] out_data_q, skid_data_q;
  logic out_vld_q, out_last_q;
  logic skid_vld_q, skid_last_q;
  logic push, pop, ram_load, empty_next;

  assign rise       = sysref & ~sysref_q;
  assign pop        = out_vld_q & m_axis.tready;
  assign push       = ram_vld_q & ~skid_vld_q;
  assign ram_load   = ~ram_vld_q | push;
  assign last_rd    = addr_q == len_q;
  assign empty_next = ~ram_vld_q & ~skid_vld_q
                    & (~out_vld_q | pop);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    loops_d = loops_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    fetch   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = length;
          loops_d = loops;
          addr_d  = '0;
          pass_d  = '0;
          state_d = sysref_align ? ARM : RUN;
        end
      end
      ARM: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (rise) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
        end else if (fetch_ok_q && ram_load) begin
          fetch = 1'b1;
          if (last_rd) begin
            addr_d = '0;
            if (pass_q != '1) pass_d = pass_q + 1'b1;
            if (loops_q != '0 &&
                pass_q == loops_q - 1'b1)
              state_d = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (empty_next) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      len_q      <= '0;
      loops_q    <= '0;
      addr_q     <= '0;
      pass_q     <= '0;
      sysref_q   <= 1'b0;
      fetch_ok_q <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      loops_q    <= loops_d;
      addr_q     <= addr_d;
      pass_q     <= pass_d;
      sysref_q   <= sysref;
      // first RUN cycle only settles the freshly latched length/loops
      fetch_ok_q <= state_q == RUN;
      done       <= done_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (fetch) ram_q <= mem[addr_q];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ram_vld_q  <= 1'b0;
      ram_last_q <= 1'b0;
    end else if (ram_load) begin
      ram_vld_q  <= fetch;
      ram_last_q <= last_rd;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
    end else if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_vld_q  <= 1'b1;
        out_last_q <= skid_last_q;
        out_data_q <= skid_data_q;
        skid_vld_q <= 1'b0;
      end else if (push) begin
        out_vld_q  <= 1'b1;
        out_last_q <= ram_last_q;
        out_data_q <= ram_q;
      end else begin
        out_vld_q  <= 1'b0;
        out_last_q <= 1'b0;
      end
    end else if (push) begin
      skid_vld_q  <= 1'b1;
      skid_last_q <= ram_last_q;
      skid_data_q <= ram_q;
    end
  end

  assign m_axis.tvalid = out_vld_q;
  assign m_axis.tlast  = out_last_q;
  assign m_axis.tdata  = out_data_q;
  assign busy          = state_q != IDLE;

endmodule

// File: tb/tb_dac_playback_tx.sv
// tb_dac_playback_tx: directed scenarios with a queue scoreboard and
// a negedge monitor that pops and compares every accepted beat.
module tb_dac_playback_tx;
  localparam int DW = 256;
  localparam int AB = 9;
  localparam int LB = 16;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          wr_en = 1'b0;
  logic [AB-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AB-1:0] length = '0;
  logic [LB-1:0] loops = '0;
  logic          sysref_align = 1'b0;
  logic          sysref = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          busy, done;
  logic          rnd_ready = 1'b0;

  dac_playback_tx_if #(.DATA_WIDTH(DW)) axis ();

  dac_playback_tx #(
    .DATA_WIDTH(DW),
    .ADDR_BITS (AB),
    .LOOP_BITS (LB)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .length      (length),
    .loops       (loops),
    .sysref_align(sysref_align),
    .sysref      (sysref),
    .start       (start),
    .stop        (stop),
    .m_axis      (axis),
    .busy        (busy),
    .done        (done)
  );

  always #5 aclk = ~aclk;

  int    checks = 0;
  int    errors = 0;
  int    beats_seen = 0;
  beat_t exp_q[$];

  logic          held_v = 1'b0;
  logic [DW+1:0] held = '0;

  task automatic chk(string name, logic [DW+1:0] act,
                     logic [DW+1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  function automatic logic [DW-1:0] w(int i);
    return {16{16'(i + 1)}};
  endfunction

  task automatic wr(int a, logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_addr = AB'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go(int len, int lp, logic al);
    length = AB'(len);
    loops = LB'(lp);
    sysref_align = al;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_run(int len, int passes);
    for (int p = 0; p < passes; p++)
      for (int a = 0; a <= len; a++)
        exp_q.push_back({a == len, w(a)});
  endtask

  task automatic first_valid(string name);
    int n;
    n = 0;
    while (!axis.tvalid && n < 50) begin
      tick();
      n++;
    end
    chk(name, n, 3);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", n);
    end
  endtask

  task automatic after_done(string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_tvalid"}, axis.tvalid, 0);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
    tick();
    chk({name, "_done_pulse"}, done, 0);
  endtask

  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      axis.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      held_v = 1'b0;
    end else begin
      if (held_v)
        chk("hold", {axis.tvalid, axis.tlast, axis.tdata}, held);
      if (axis.tvalid && axis.tready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat: got tdata %0h, required no beat", axis.tdata);
        end else begin
          chk("beat", {1'b1, axis.tlast, axis.tdata},
              {1'b1, exp_q.pop_front()});
        end
      end
      held_v = axis.tvalid && !axis.tready;
      held = {axis.tvalid, axis.tlast, axis.tdata};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, cnt, d;
    tick(2);
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_tlast", axis.tlast, 0);
    chk("rst_tdata", axis.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    aresetn = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) wr(i, w(i));

    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("idle_stop_busy", busy, 0);

    // start and stop together in IDLE: start wins
    expect_run(3, 2);
    stop = 1'b1;
    go(3, 2, 1'b0);
    stop = 1'b0;
    first_valid("lat_noalign");
    wait_done(n);
    chk("run_len_noalign", n, 8);
    after_done("t1");

    // rise coincident with start must be ignored
    expect_run(3, 2);
    sysref = 1'b1;
    go(3, 2, 1'b1);
    sysref = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (axis.tvalid) cnt++;
      tick();
    end
    chk("arm_quiet", cnt, 0);
    chk("arm_busy", busy, 1);
    sysref = 1'b1;
    tick();
    first_valid("lat_align");
    sysref = 1'b0;
    wait_done(n);
    chk("run_len_align", n, 8);
    after_done("t2");

    expect_run(0, 12);
    base = beats_seen;
    go(0, 0, 1'b0);
    n = 0;
    while (beats_seen - base < 10 && n < 200) begin
      tick();
      n++;
    end
    chk("stop_reach10", beats_seen - base >= 10, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(n);
    d = beats_seen - base;
    chk("stop_delivered", d >= 10 && d <= 12, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (axis.tvalid) cnt++;
    end
    chk("stop_quiet", cnt, 0);
    exp_q.delete();

    expect_run(7, 1);
    rnd_ready = 1'b1;
    go(7, 1, 1'b0);
    wait_done(n);
    rnd_ready = 1'b0;
    tick();
    after_done("t4");

    go(3, 0, 1'b0);
    n = 0;
    while (!axis.tvalid && n < 50) begin
      tick();
      n++;
    end
    chk("rst_mid_tvalid_pre", axis.tvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("rst_mid_tvalid", axis.tvalid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    tick(2);
    aresetn = 1'b1;
    exp_q.delete();
    tick();
    expect_run(3, 1);
    go(3, 1, 1'b0);
    first_valid("lat_after_rst");
    wait_done(n);
    after_done("t5");

    // word 2 rewritten after its pass-1 read, before pass 2
    for (int p = 0; p < 3; p++)
      for (int a = 0; a <= 3; a++)
        exp_q.push_back({a == 3,
          (p > 0 && a == 2) ? {16{16'hBEEF}} : w(a)});
    go(3, 3, 1'b0);
    tick(4);
    wr(2, {16{16'hBEEF}});
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    after_done("t6");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
